// File: rtl/riscv_biu_arb_pkg.sv
// Shared BIU types and arbiter helpers for riscv_biu_arb.
// Covers transfer size/type/protection encodings, the beat-count helper and the arbiter state type.
package riscv_biu_arb_pkg;

  localparam int unsigned BEATS_W = 5;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

  // Undefined-length INCR cannot be tracked, so it is counted as a single beat.
  function automatic logic [BEATS_W-1:0] biu_type2beats(input biu_type_t t);
    case (t)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_biu_arb_if.sv
// One BIU-style port: the master modport issues requests, the slave modport answers them.
interface riscv_biu_arb_if
  import riscv_biu_arb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PLEN = 34,
  parameter int unsigned TAGW = 1
) ();

  logic            stb;
  logic            stb_ack;
  logic            d_ack;
  logic [PLEN-1:0] adri;
  logic [PLEN-1:0] adro;
  biu_size_t       size;
  biu_type_t       typ;
  biu_prot_t       prot;
  logic            we;
  logic            lock;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] q;
  logic            ack;
  logic            err;
  logic [TAGW-1:0] tagi;
  logic [TAGW-1:0] tago;

  modport master (
    output stb, adri, size, typ, prot, we, lock, d, tagi,
    input  stb_ack, d_ack, adro, q, ack, err, tago
  );

  modport slave (
    input  stb, adri, size, typ, prot, we, lock, d, tagi,
    output stb_ack, d_ack, adro, q, ack, err, tago
  );

endinterface

// File: rtl/riscv_biu_arb_cnt.sv
// Outstanding-beat counter for riscv_biu_arb, with the admission check for the next burst.
module riscv_biu_arb_cnt
  import riscv_biu_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               acc,
  input  logic [BEATS_W-1:0] beats,
  input  logic               done,
  output logic [CNT_W-1:0]   cnt,
  output logic               beat_vld,
  output logic               cnt_zero_nxt,
  output logic               cap_ok
);

  logic [CNT_W:0] cnt_add;
  logic [CNT_W:0] cnt_nxt;

  // A completion only counts when something is outstanding or is being accepted right now.
  assign beat_vld     = done & ((cnt != '0) | acc);
  assign cnt_add      = {1'b0, cnt} + (acc ? (CNT_W+1)'(beats) : (CNT_W+1)'(0));
  assign cnt_nxt      = cnt_add - (CNT_W+1)'(beat_vld);
  assign cnt_zero_nxt = (cnt_nxt == '0);
  assign cap_ok       = ({1'b0, cnt} + (CNT_W+1)'(beats)) <= (CNT_W+1)'(MAX_OUTSTANDING);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else       cnt <= CNT_W'(cnt_nxt);
  end

endmodule

// File: rtl/riscv_biu_arb.sv
// Shares one downstream BIU port between the instruction and data memory controllers.
// Define RV12_BIU_ARB_RR_EN for round-robin tie-break; otherwise data wins ties.
module riscv_biu_arb
  import riscv_biu_arb_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned PLEN            = (XLEN == 32) ? 34 : 56,
  parameter int unsigned BIUTAG_SIZE     = (XLEN > 32) ? $clog2(XLEN / 32) : 1,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  riscv_biu_arb_if.slave  ibiu,
  riscv_biu_arb_if.slave  dbiu,
  riscv_biu_arb_if.master biu
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic               own_stb;
  logic               own_lock;
  biu_type_t          own_typ;
  logic [BEATS_W-1:0] own_beats;
  logic               stb_dn;
  logic               acc;
  logic               beat_vld;
  logic               cnt_zero_nxt;
  logic               cap_ok;
  logic               pick_d;
  logic [CNT_W-1:0]   cnt;

  // Owner's request-side controls.
  always_comb begin
    own_stb  = 1'b0;
    own_lock = 1'b0;
    own_typ  = SINGLE;
    unique case (state)
      GNT_I: begin own_stb = ibiu.stb; own_lock = ibiu.lock; own_typ = ibiu.typ; end
      GNT_D: begin own_stb = dbiu.stb; own_lock = dbiu.lock; own_typ = dbiu.typ; end
      default: ;
    endcase
  end

  assign own_beats = biu_type2beats(own_typ);
  assign stb_dn    = own_stb & cap_ok;
  assign acc       = stb_dn & biu.stb_ack;

  riscv_biu_arb_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_cnt (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .acc          (acc),
    .beats        (own_beats),
    .done         (biu.ack | biu.err),
    .cnt          (cnt),
    .beat_vld     (beat_vld),
    .cnt_zero_nxt (cnt_zero_nxt),
    .cap_ok       (cap_ok)
  );

  // Downstream payload from the owner; responses go back to the owner only.
  always_comb begin
    biu.stb      = stb_dn;
    biu.adri     = PLEN'(0);
    biu.size     = BYTE;
    biu.typ      = SINGLE;
    biu.prot     = '0;
    biu.we       = 1'b0;
    biu.lock     = 1'b0;
    biu.d        = XLEN'(0);
    biu.tagi     = BIUTAG_SIZE'(0);
    ibiu.stb_ack = 1'b0;
    ibiu.d_ack   = 1'b0;
    ibiu.ack     = 1'b0;
    ibiu.err     = 1'b0;
    ibiu.adro    = PLEN'(0);
    ibiu.q       = XLEN'(0);
    ibiu.tago    = BIUTAG_SIZE'(0);
    dbiu.stb_ack = 1'b0;
    dbiu.d_ack   = 1'b0;
    dbiu.ack     = 1'b0;
    dbiu.err     = 1'b0;
    dbiu.adro    = PLEN'(0);
    dbiu.q       = XLEN'(0);
    dbiu.tago    = BIUTAG_SIZE'(0);
    unique case (state)
      GNT_I: begin
        biu.adri     = ibiu.adri;
        biu.size     = ibiu.size;
        biu.typ      = ibiu.typ;
        biu.prot     = ibiu.prot;
        biu.we       = ibiu.we;
        biu.lock     = ibiu.lock;
        biu.d        = ibiu.d;
        biu.tagi     = ibiu.tagi;
        ibiu.stb_ack = acc;
        ibiu.d_ack   = biu.d_ack;
        ibiu.ack     = biu.ack & beat_vld;
        ibiu.err     = biu.err & beat_vld;
        ibiu.adro    = biu.adro;
        ibiu.q       = biu.q;
        ibiu.tago    = biu.tago;
      end
      GNT_D: begin
        biu.adri     = dbiu.adri;
        biu.size     = dbiu.size;
        biu.typ      = dbiu.typ;
        biu.prot     = dbiu.prot;
        biu.we       = dbiu.we;
        biu.lock     = dbiu.lock;
        biu.d        = dbiu.d;
        biu.tagi     = dbiu.tagi;
        dbiu.stb_ack = acc;
        dbiu.d_ack   = biu.d_ack;
        dbiu.ack     = biu.ack & beat_vld;
        dbiu.err     = biu.err & beat_vld;
        dbiu.adro    = biu.adro;
        dbiu.q       = biu.q;
        dbiu.tago    = biu.tago;
      end
      default: ;
    endcase
  end

`ifdef RV12_BIU_ARB_RR_EN
  logic last_d;

  // Remembers who was granted last; a tie goes to the other requester.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                             last_d <= 1'b1;
    else if ((state_nxt != state) && (state_nxt != IDLE))  last_d <= (state_nxt == GNT_D);
  end

  assign pick_d = dbiu.stb & (~ibiu.stb | ~last_d);
`else
  assign pick_d = dbiu.stb;
`endif

  // Grant is released only when the owner is idle, unlocked and fully drained.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_d)        state_nxt = GNT_D;
        else if (ibiu.stb) state_nxt = GNT_I;
      end
      GNT_I: if (!ibiu.stb && !ibiu.lock && cnt_zero_nxt) state_nxt = dbiu.stb ? GNT_D : IDLE;
      GNT_D: if (!dbiu.stb && !dbiu.lock && cnt_zero_nxt) state_nxt = ibiu.stb ? GNT_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

endmodule

// File: tb/tb_riscv_biu_arb.sv
// Directed bench for riscv_biu_arb with a per-cycle reference model of ownership and outstanding beats.
module tb_riscv_biu_arb;
  import riscv_biu_arb_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PLEN = 34;
  localparam int unsigned TAGW = 1;
  localparam int unsigned MAXO = 16;
  localparam int unsigned DNW  = 1 + PLEN + 3 + 3 + 3 + 1 + 1 + XLEN + TAGW;
  localparam int unsigned RSW  = 4 + PLEN + XLEN + TAGW;
`ifdef RV12_BIU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   first_d;

  always #5 clk = ~clk;

  riscv_biu_arb_if #(.XLEN(XLEN), .PLEN(PLEN), .TAGW(TAGW)) ibus ();
  riscv_biu_arb_if #(.XLEN(XLEN), .PLEN(PLEN), .TAGW(TAGW)) dbus ();
  riscv_biu_arb_if #(.XLEN(XLEN), .PLEN(PLEN), .TAGW(TAGW)) dn ();

  riscv_biu_arb #(
    .XLEN(XLEN), .PLEN(PLEN), .BIUTAG_SIZE(TAGW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ibiu(ibus), .dbiu(dbus), .biu(dn)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int beats(input biu_type_t t);
    if (t == SINGLE || t == INCR) return 1;
    return 4 << ((int'(t) - 2) / 2);
  endfunction

  // Reference model: owner 0=none 1=instr 2=data, plus plain integer outstanding count.
  int m_own = 0;
  int m_cnt = 0;
  bit m_last_d = 1'b1;

  always @(negedge clk) begin
    logic o_stb, o_lock, e_stb, accd, beat, oth_stb;
    int bt, nc;
    logic [DNW-1:0] e_dn;
    logic [RSW-1:0] e_rs, e_i, e_d;
    if (mon_en) begin
      o_stb  = (m_own == 1) ? ibus.stb  : (m_own == 2) ? dbus.stb  : 1'b0;
      o_lock = (m_own == 1) ? ibus.lock : (m_own == 2) ? dbus.lock : 1'b0;
      bt     = (m_own == 1) ? beats(ibus.typ) : (m_own == 2) ? beats(dbus.typ) : 1;
      e_stb  = o_stb && (m_cnt + bt <= int'(MAXO));
      accd   = e_stb && dn.stb_ack;
      beat   = (dn.ack || dn.err) && (m_cnt > 0 || accd);
      e_dn   = '0;
      if (m_own == 1) e_dn = {e_stb, ibus.adri, ibus.size, ibus.typ, ibus.prot, ibus.we, ibus.lock, ibus.d, ibus.tagi};
      if (m_own == 2) e_dn = {e_stb, dbus.adri, dbus.size, dbus.typ, dbus.prot, dbus.we, dbus.lock, dbus.d, dbus.tagi};
      e_rs = {accd, dn.d_ack, dn.ack && beat, dn.err && beat, dn.adro, dn.q, dn.tago};
      e_i  = (m_own == 1) ? e_rs : '0;
      e_d  = (m_own == 2) ? e_rs : '0;
      chk("mon downstream", 128'({dn.stb, dn.adri, dn.size, dn.typ, dn.prot, dn.we, dn.lock, dn.d, dn.tagi}), 128'(e_dn));
      chk("mon ibiu resp", 128'({ibus.stb_ack, ibus.d_ack, ibus.ack, ibus.err, ibus.adro, ibus.q, ibus.tago}), 128'(e_i));
      chk("mon dbiu resp", 128'({dbus.stb_ack, dbus.d_ack, dbus.ack, dbus.err, dbus.adro, dbus.q, dbus.tago}), 128'(e_d));
      chk("mon cnt", 128'(dut.u_cnt.cnt), 128'(m_cnt));
      if (rst) begin
        m_own = 0; m_cnt = 0; m_last_d = 1'b1;
      end else begin
        nc      = m_cnt + (accd ? bt : 0) - (beat ? 1 : 0);
        oth_stb = (m_own == 1) ? dbus.stb : ibus.stb;
        if (m_own == 0) begin
          if (dbus.stb && (!ibus.stb || !RR || !m_last_d)) m_own = 2;
          else if (ibus.stb)                               m_own = 1;
        end else if (!o_stb && !o_lock && nc == 0) begin
          m_own = oth_stb ? 3 - m_own : 0;
        end
        if (m_own != 0) m_last_d = (m_own == 2);
        m_cnt = nc;
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic samp(); @(negedge clk); endtask

  task automatic dnd(input logic sa, input logic a, input logic [XLEN-1:0] q);
    dn.stb_ack = sa; dn.ack = a; dn.err = 1'b0; dn.d_ack = 1'b0;
    dn.q = q; dn.adro = PLEN'(q) << 2; dn.tago = q[0];
  endtask

  task automatic req(input bit dsel, input logic s, input biu_type_t t, input logic [PLEN-1:0] a,
                     input logic w, input logic lk);
    if (dsel) begin dbus.stb = s; dbus.typ = t; dbus.adri = a; dbus.we = w; dbus.lock = lk; end
    else      begin ibus.stb = s; ibus.typ = t; ibus.adri = a; ibus.we = w; ibus.lock = lk; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by 100000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ibus.size = WORD; ibus.prot = 3'b100; ibus.d = 32'h0; ibus.tagi = 1'b0;
    dbus.size = WORD; dbus.prot = 3'b001; dbus.d = 32'h0; dbus.tagi = 1'b1;
    req(0, 0, SINGLE, '0, 0, 0); req(1, 0, SINGLE, '0, 0, 0); dnd(0, 0, 0);
    step(); step(); rst = 1'b0; mon_en = 1'b1;
    samp();
    chk("reset stb", 128'(dn.stb), 128'(0));
    chk("reset adri", 128'(dn.adri), 128'(0));
    chk("reset ibiu stb_ack", 128'(ibus.stb_ack), 128'(0));
    chk("reset cnt", 128'(dut.u_cnt.cnt), 128'(0));

    // tie: both request together
    first_d = !RR;
    step(); req(0, 1, SINGLE, 'h200, 0, 0); req(1, 1, SINGLE, 'h300, 0, 0); samp();
    chk("tie idle stb", 128'(dn.stb), 128'(0));
    step(); samp();
    chk("tie first owner", 128'(dn.adri), first_d ? 128'h300 : 128'h200);
    chk("tie first stb", 128'(dn.stb), 128'(1));
    step(); dnd(1, 0, 0); samp();
    chk("tie first stb_ack", 128'(first_d ? dbus.stb_ack : ibus.stb_ack), 128'(1));
    chk("tie other stb_ack", 128'(first_d ? ibus.stb_ack : dbus.stb_ack), 128'(0));
    step(); dnd(0, 1, 32'hA); req(first_d, 0, SINGLE, first_d ? 'h300 : 'h200, 0, 0); samp();
    chk("tie first ack", 128'(first_d ? dbus.ack : ibus.ack), 128'(1));
    step(); dnd(0, 0, 0); samp();
    chk("tie second owner no bubble", 128'(dn.adri), first_d ? 128'h200 : 128'h300);
    chk("tie second stb", 128'(dn.stb), 128'(1));
    step(); dnd(1, 0, 0); samp();
    step(); dnd(0, 1, 32'hB); req(!first_d, 0, SINGLE, first_d ? 'h200 : 'h300, 0, 0); samp();
    chk("tie second q", 128'(first_d ? ibus.q : dbus.q), 128'hB);
    step(); dnd(0, 0, 0); samp();
    chk("tie back idle", 128'(dn.adri), 128'(0));

    // single instruction fetch
    step(); req(0, 1, SINGLE, 'h100, 0, 0); samp();
    chk("fetch stb cycle0", 128'(dn.stb), 128'(0));
    step(); samp();
    chk("fetch stb cycle1", 128'(dn.stb), 128'(1));
    step(); dnd(1, 0, 0); samp();
    chk("fetch stb_ack", 128'(ibus.stb_ack), 128'(1));
    step(); dnd(0, 1, 32'h13); req(0, 0, SINGLE, 'h100, 0, 0); samp();
    chk("fetch q", 128'(ibus.q), 128'h13);
    chk("fetch ack", 128'(ibus.ack), 128'(1));
    chk("fetch dbiu ack", 128'(dbus.ack), 128'(0));
    step(); dnd(0, 0, 0); samp();
    chk("fetch idle", 128'(dn.adri), 128'(0));

    // instruction INCR8 refill with a data request arriving after beat 2; beat 5 errors
    step(); req(0, 1, INCR8, 'h1000, 0, 0); samp();
    step(); samp();
    chk("refill type", 128'(dn.typ), 128'(INCR8));
    step(); dnd(1, 0, 0); samp();
    for (int k = 1; k <= 8; k++) begin
      step(); dnd(0, (k != 5), XLEN'(k)); dn.err = (k == 5);
      if (k == 1) req(0, 0, INCR8, 'h1000, 0, 0);
      if (k == 3) req(1, 1, SINGLE, 'h2000, 0, 0);
      samp();
      chk("refill owner held", 128'(dn.adri), 128'h1000);
      if (k == 1) chk("refill cnt after accept", 128'(dut.u_cnt.cnt), 128'(8));
      if (k == 5) chk("refill err routed", 128'(ibus.err), 128'(1));
    end
    step(); dnd(0, 0, 0); samp();
    chk("refill d granted", 128'(dn.adri), 128'h2000);
    chk("refill cnt drained", 128'(dut.u_cnt.cnt), 128'(0));
    step(); dnd(1, 0, 0); samp();
    step(); dnd(0, 1, 32'h5); req(1, 0, SINGLE, 'h2000, 0, 0); samp();
    chk("refill d ack", 128'(dbus.ack), 128'(1));
    step(); dnd(0, 0, 0); samp();

    // locked AMO on the data port with an instruction request pending
    step(); req(1, 1, SINGLE, 'h3000, 0, 1); samp();
    step(); req(0, 1, SINGLE, 'h100, 0, 0); samp();
    chk("amo lock out", 128'(dn.lock), 128'(1));
    step(); dnd(1, 0, 0); samp();
    step(); dnd(0, 1, 32'h55); req(1, 0, SINGLE, 'h3000, 0, 1); samp();
    chk("amo read q", 128'(dbus.q), 128'h55);
    for (int k = 0; k < 2; k++) begin
      step(); dnd(0, 0, 0); samp();
      chk("amo held idle", 128'(dn.adri), 128'h3000);
    end
    step(); dbus.d = 32'hAA; req(1, 1, SINGLE, 'h3000, 1, 1); samp();
    chk("amo write data", 128'(dn.d), 128'hAA);
    step(); dnd(1, 0, 0); dn.d_ack = 1'b1; samp();
    chk("amo d_ack", 128'(dbus.d_ack), 128'(1));
    step(); dnd(0, 0, 0); req(1, 0, SINGLE, 'h3000, 1, 0); samp();
    chk("amo held for ack", 128'(dn.adri), 128'h3000);
    step(); dnd(0, 1, 32'h0); samp();
    chk("amo final ack", 128'(dbus.ack), 128'(1));
    step(); dnd(0, 0, 0); samp();
    chk("amo then i granted", 128'(dn.adri), 128'h100);
    step(); dnd(1, 0, 0); samp();
    step(); dnd(0, 1, 32'h7); req(0, 0, SINGLE, 'h100, 0, 0); samp();
    step(); dnd(0, 0, 0); samp();

    // outstanding cap: INCR16 then SINGLE from the same requester
    step(); req(0, 1, INCR16, 'h4000, 0, 0); samp();
    step(); samp();
    chk("cap first stb", 128'(dn.stb), 128'(1));
    step(); dnd(1, 0, 0); samp();
    step(); dnd(0, 0, 0); req(0, 1, SINGLE, 'h4040, 0, 0); samp();
    chk("cap blocked a", 128'(dn.stb), 128'(0));
    step(); samp();
    chk("cap blocked b", 128'(dn.stb), 128'(0));
    step(); dnd(0, 1, 32'h1); samp();
    step(); dnd(0, 0, 0); samp();
    chk("cap released", 128'(dn.stb), 128'(1));
    chk("cap cnt", 128'(dut.u_cnt.cnt), 128'(15));
    step(); dnd(1, 0, 0); samp();
    for (int k = 0; k < 16; k++) begin
      step(); dnd(0, 1, XLEN'(k)); if (k == 0) req(0, 0, SINGLE, 'h4040, 0, 0); samp();
    end
    step(); dnd(0, 0, 0); samp();
    chk("cap idle", 128'(dn.adri), 128'(0));

    // reset during beat 3 of an INCR8
    step(); req(0, 1, INCR8, 'h5000, 0, 0); samp();
    step(); samp();
    step(); dnd(1, 0, 0); samp();
    step(); dnd(0, 1, 32'h1); req(0, 0, INCR8, 'h5000, 0, 0); samp();
    step(); dnd(0, 1, 32'h2); samp();
    step(); dnd(0, 1, 32'h3); rst = 1'b1; samp();
    step(); rst = 1'b0; dnd(0, 0, 0); samp();
    chk("rst stb", 128'(dn.stb), 128'(0));
    chk("rst cnt", 128'(dut.u_cnt.cnt), 128'(0));
    chk("rst adri", 128'(dn.adri), 128'(0));
    step(); dnd(0, 1, 32'h77); samp();
    chk("stray ack ibiu", 128'(ibus.ack), 128'(0));
    chk("stray ack dbiu", 128'(dbus.ack), 128'(0));
    chk("stray q ibiu", 128'(ibus.q), 128'(0));
    step(); dnd(0, 0, 0); samp();
    chk("stray cnt", 128'(dut.u_cnt.cnt), 128'(0));

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
